// File: rtl/param_main_fifo.sv
// Parametrised main FIFO for the PCIe transmit data path, with occupancy, thresholds and sticky errors.
// Optional macro FWFT_EN selects first-word-fall-through reads; default is a registered 1-cycle read.
module param_main_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  wr_enable,
    input  logic                  rd_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CNT_WIDTH-1:0]  umbral_almost_full,
    input  logic [CNT_WIDTH-1:0]  umbral_almost_empty,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full_fifo,
    output logic                  empty_fifo,
    output logic                  almost_full_fifo,
    output logic                  almost_empty_fifo,
    output logic                  overflow_error,
    output logic                  underflow_error,
    output logic [CNT_WIDTH-1:0]  fill_level
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_accept;
    logic                  wr_accept;

    assign full_fifo         = (fill_level == DEPTH_CNT);
    assign empty_fifo        = (fill_level == '0);
    assign almost_full_fifo  = (fill_level >= umbral_almost_full);
    assign almost_empty_fifo = (fill_level <= umbral_almost_empty);

    // A write at full only goes through when a pop frees the slot in the same cycle.
    assign rd_accept = rd_enable & ~empty_fifo;
    assign wr_accept = wr_enable & (~full_fifo | rd_accept);

    always_ff @(posedge clk) begin
        if (init && wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fill_level      <= '0;
            overflow_error  <= 1'b0;
            underflow_error <= 1'b0;
        end else if (!init) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fill_level      <= '0;
            overflow_error  <= 1'b0;
            underflow_error <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   fill_level <= fill_level + CNT_WIDTH'(1);
                2'b01:   fill_level <= fill_level - CNT_WIDTH'(1);
                default: fill_level <= fill_level;
            endcase
            if (wr_enable && full_fifo && !rd_accept) begin
                overflow_error <= 1'b1;
            end
            if (rd_enable && empty_fifo) begin
                underflow_error <= 1'b1;
            end
        end
    end

`ifdef FWFT_EN
    assign data_out  = empty_fifo ? '0 : mem[rd_ptr];
    assign valid_out = ~empty_fifo;
`else
    // data_out keeps the last popped word; only valid_out drops when nothing is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (!init) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= rd_accept;
            if (rd_accept) begin
                data_out <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_main_fifo.sv
// Randomised and directed bench for param_main_fifo against a queue-based reference model.
module tb_param_main_fifo;

    localparam int DW    = 6;
    localparam int AW    = 2;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic          wr_enable;
    logic          rd_enable;
    logic [DW-1:0] data_in;
    logic [CW-1:0] umbral_almost_full;
    logic [CW-1:0] umbral_almost_empty;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full_fifo;
    logic          empty_fifo;
    logic          almost_full_fifo;
    logic          almost_empty_fifo;
    logic          overflow_error;
    logic          underflow_error;
    logic [CW-1:0] fill_level;

    param_main_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .init                (init),
        .wr_enable           (wr_enable),
        .rd_enable           (rd_enable),
        .data_in             (data_in),
        .umbral_almost_full  (umbral_almost_full),
        .umbral_almost_empty (umbral_almost_empty),
        .data_out            (data_out),
        .valid_out           (valid_out),
        .full_fifo           (full_fifo),
        .empty_fifo          (empty_fifo),
        .almost_full_fifo    (almost_full_fifo),
        .almost_empty_fifo   (almost_empty_fifo),
        .overflow_error      (overflow_error),
        .underflow_error     (underflow_error),
        .fill_level          (fill_level)
    );

    always #5 clk = ~clk;

    // Reference model state
    int unsigned q[$];
    int unsigned m_dout;
    bit          m_valid;
    bit          m_ovf;
    bit          m_udf;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_dout  = 0;
        m_valid = 0;
        m_ovf   = 0;
        m_udf   = 0;
    endtask

    task automatic check_all(input string ctx);
        int unsigned sz;
        sz = q.size();
        check({ctx, ".fill"},   32'(fill_level),        sz);
        check({ctx, ".empty"},  32'(empty_fifo),        32'(sz == 0));
        check({ctx, ".full"},   32'(full_fifo),         32'(sz == DEPTH));
        check({ctx, ".afull"},  32'(almost_full_fifo),  32'(sz >= int'(umbral_almost_full)));
        check({ctx, ".aempty"}, 32'(almost_empty_fifo), 32'(sz <= int'(umbral_almost_empty)));
        check({ctx, ".ovf"},    32'(overflow_error),    32'(m_ovf));
        check({ctx, ".udf"},    32'(underflow_error),   32'(m_udf));
`ifdef FWFT_EN
        check({ctx, ".valid"},  32'(valid_out),         32'(sz != 0));
        check({ctx, ".dout"},   32'(data_out),          (sz != 0) ? q[0] : 0);
`else
        check({ctx, ".valid"},  32'(valid_out),         32'(m_valid));
        check({ctx, ".dout"},   32'(data_out),          m_dout);
`endif
    endtask

    // One clock: drive inputs, advance the model by the rules, then sample after the edge.
    task automatic cycle(input bit wr, input bit rd, input int unsigned din, input bit ini, input string ctx);
        bit was_empty;
        bit was_full;
        bit racc;
        bit wacc;
        wr_enable = wr;
        rd_enable = rd;
        data_in   = DW'(din);
        init      = ini;
        if (!ini) begin
            model_clear();
        end else begin
            was_empty = (q.size() == 0);
            was_full  = (q.size() == DEPTH);
            racc      = rd && !was_empty;
            wacc      = wr && (!was_full || racc);
            m_valid   = racc;
            if (racc) m_dout = q.pop_front();
            if (wacc) q.push_back(din % (1 << DW));
            if (wr && was_full && !racc) m_ovf = 1;
            if (rd && was_empty) m_udf = 1;
        end
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic async_reset(input string ctx);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_all({ctx, ".imm"});
        @(posedge clk);
        #1;
        check_all({ctx, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        init                = 1'b1;
        wr_enable           = 1'b0;
        rd_enable           = 1'b0;
        data_in             = '0;
        umbral_almost_full  = CW'(3);
        umbral_almost_empty = CW'(1);
        model_clear();
        #1;
        check_all("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: async reset mid-operation
        for (int i = 1; i <= 3; i++) cycle(1, 0, i, 1, "t1.wr");
        async_reset("t1");

        // 2: fill to full, then overflow
        for (int i = 1; i <= 4; i++) cycle(1, 0, i, 1, "t2.wr");
        cycle(1, 0, 5, 1, "t2.ovf");

`ifdef FWFT_EN
        check_all("t3.pre");
`endif
        // 3: drain and underflow
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, "t3.rd");
        cycle(0, 1, 0, 1, "t3.udf");

        // 4: simultaneous wr+rd at full and at empty
        cycle(0, 0, 0, 0, "t4.init");
        for (int i = 1; i <= 4; i++) cycle(1, 0, i, 1, "t4.fill");
        cycle(1, 1, 'h2A, 1, "t4.full_wr_rd");
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, "t4.drain");
        cycle(1, 1, 'h15, 1, "t4.empty_wr_rd");
        cycle(0, 1, 0, 1, "t4.rd15");

        // 5: pointer wrap with interleaved reads
        cycle(0, 0, 0, 0, "t5.init");
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, i, 1, "t5.wr");
            if (i >= 1) cycle(0, 1, 0, 1, "t5.rd");
        end
        cycle(0, 1, 0, 1, "t5.last");

        // 6: both errors set, fill_level 2, then soft clear
        cycle(0, 1, 0, 1, "t6.udf");
        for (int i = 0; i < 6; i++) cycle(1, 0, i + 7, 1, "t6.fill");
        cycle(0, 1, 0, 1, "t6.rd");
        cycle(0, 1, 0, 1, "t6.rd");
        cycle(0, 0, 0, 0, "t6.init");

        // Threshold corners
        umbral_almost_full  = '0;
        umbral_almost_empty = CW'(DEPTH);
        cycle(1, 0, 'h3F, 1, "thr.corner");
        cycle(1, 0, 'h3E, 1, "thr.corner");

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                umbral_almost_full  = CW'($urandom_range(0, 7));
                umbral_almost_empty = CW'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 79) == 0) begin
                async_reset("rnd.rst");
            end else begin
                cycle(1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 39) != 0, "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
